// File: rtl/amiga_clock_gen.sv
// amiga_clock_gen: master-clock derived colour-clock phases, E7M/CDAC pair,
// 6800-style E clock, stretched system reset with keyboard reset request and
// a genlock SYNC input. Every output is registered from the next-state values,
// so each output reflects the current phase count with no added lag.
module amiga_clock_gen #(
  parameter int PHASES = 4,
  parameter int STEP   = 2,
  parameter int EDIV   = 10,
  parameter int ELOW   = 6,
  parameter int RSTLEN = 16,
  parameter int KHOLD  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sync,
  input  logic              i_krst_n,
  output logic [PHASES-1:0] o_c,
  output logic [PHASES-1:0] o_c_n,
  output logic              o_e7m,
  output logic              o_cdac,
  output logic              o_e,
  output logic              o_e_rise,
  output logic              o_rsto_n
);

  localparam int PERIOD  = PHASES * STEP;
  localparam int HALF    = PERIOD / 2;
  localparam int QUARTER = PERIOD / 4;
  localparam int CW      = $clog2(PERIOD);
  localparam int CW1     = CW + 1;
  localparam int EW      = $clog2(EDIV);
  localparam int KW      = $clog2(KHOLD + 1);
  localparam int RW      = $clog2(RSTLEN + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [EW-1:0] E_LAST   = EW'(EDIV - 1);
  localparam logic [EW-1:0] E_LOW    = EW'(ELOW);
  localparam logic [KW-1:0] K_MAX    = KW'(KHOLD);
  localparam logic [KW-1:0] K_PRE    = KW'(KHOLD - 1);
  localparam logic [RW-1:0] R_LOAD   = RW'(RSTLEN);

  // Reject configurations the phase and E arithmetic cannot represent.
  if (PHASES < 2 || (PERIOD % 4) != 0 || ELOW < 1 || ELOW >= EDIV || KHOLD < 1 || RSTLEN < 1) begin : g_bad_cfg
    $error("amiga_clock_gen: illegal parameter combination");
  end

  // Phase k is high for the half period starting k*STEP counts after phase 0.
  function automatic logic [PHASES-1:0] f_phase(input logic [CW-1:0] cnt);
    logic [CW:0] w_d;
    f_phase = '0;
    for (int k = 0; k < PHASES; k++) begin
      if ({1'b0, cnt} >= CW1'(k * STEP)) begin
        w_d = {1'b0, cnt} - CW1'(k * STEP);
      end else begin
        w_d = {1'b0, cnt} + CW1'(PERIOD - k * STEP);
      end
      f_phase[k] = (w_d < CW1'(HALF));
    end
  endfunction

  // E7M runs at twice the phase rate: high for the first quarter of each half.
  function automatic logic f_e7m(input logic [CW-1:0] cnt);
    logic [CW-1:0] w_m;
    w_m   = (cnt >= CNT_HALF) ? (cnt - CNT_HALF) : cnt;
    f_e7m = (w_m < CW'(QUARTER));
  endfunction

  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic [EW-1:0] r_ecnt;
  logic          r_ks1;
  logic          r_ks2;
  logic [KW-1:0] r_kcnt;
  logic [RW-1:0] r_rcnt;

  logic [CW-1:0] w_cnt_nxt;
  logic          w_run_nxt;
  logic          w_tick;
  logic [EW-1:0] w_ecnt_nxt;
  logic [KW-1:0] w_kcnt_nxt;
  logic          w_ktrig;
  logic [RW-1:0] w_rcnt_nxt;

  // Next-state for phase, E, keyboard-hold and reset-stretch counters.
  // r_run suppresses the mid-period tick until the first wrap (or SYNC)
  // after reset, so the first tick lands on a full-period boundary.
  always_comb begin
    w_cnt_nxt  = r_cnt + 1'b1;
    w_run_nxt  = r_run;
    w_tick     = 1'b0;
    w_ecnt_nxt = r_ecnt;
    w_kcnt_nxt = r_kcnt;
    w_ktrig    = 1'b0;
    w_rcnt_nxt = r_rcnt;

    if (i_sync || (r_cnt == CNT_LAST)) begin
      w_cnt_nxt = '0;
    end

    w_tick = (w_cnt_nxt == '0) || (r_run && (w_cnt_nxt == CNT_HALF));
    if (w_cnt_nxt == '0) begin
      w_run_nxt = 1'b1;
    end

    if (w_tick) begin
      w_ecnt_nxt = (r_ecnt == E_LAST) ? '0 : (r_ecnt + 1'b1);
    end

    // Saturating at KHOLD gives exactly one trigger per key press.
    if (r_ks2) begin
      w_kcnt_nxt = '0;
    end else if (w_tick && (r_kcnt != K_MAX)) begin
      w_kcnt_nxt = r_kcnt + 1'b1;
      w_ktrig    = (r_kcnt == K_PRE);
    end

    if (w_ktrig) begin
      w_rcnt_nxt = R_LOAD;
    end else if (w_tick && (r_rcnt != '0)) begin
      w_rcnt_nxt = r_rcnt - 1'b1;
    end
  end

  // Internal counter state and the keyboard request synchroniser.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_ecnt <= '0;
      r_ks1  <= 1'b1;
      r_ks2  <= 1'b1;
      r_kcnt <= '0;
      r_rcnt <= R_LOAD;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_run  <= w_run_nxt;
      r_ecnt <= w_ecnt_nxt;
      r_ks1  <= i_krst_n;
      r_ks2  <= r_ks1;
      r_kcnt <= w_kcnt_nxt;
      r_rcnt <= w_rcnt_nxt;
    end
  end

  // Output registers decoded from next-state so they track the counters exactly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_c      <= f_phase('0);
      o_c_n    <= ~f_phase('0);
      o_e7m    <= 1'b1;
      o_cdac   <= 1'b0;
      o_e      <= 1'b0;
      o_e_rise <= 1'b0;
      o_rsto_n <= 1'b0;
    end else begin
      o_c      <= f_phase(w_cnt_nxt);
      o_c_n    <= ~f_phase(w_cnt_nxt);
      o_e7m    <= f_e7m(w_cnt_nxt);
      o_cdac   <= ~f_e7m(w_cnt_nxt);
      o_e      <= (w_ecnt_nxt >= E_LOW);
      o_e_rise <= w_tick && (w_ecnt_nxt == E_LOW);
      o_rsto_n <= (w_rcnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_amiga_clock_gen.sv
// Testbench for amiga_clock_gen: default configuration plus an 8-phase,
// STEP=1 instance sharing the same inputs, both checked against a
// behavioural model of the phase/tick/reset rules.
module tb_amiga_clock_gen;

  localparam int PER    = 8;
  localparam int EDIV   = 10;
  localparam int ELOW   = 6;
  localparam int RSTLEN = 16;
  localparam int KHOLD  = 8;

  logic clk = 1'b0;
  logic rst, sync, krst_n;

  logic [3:0] c, c_n;
  logic       e7m, cdac, e, e_rise, rsto_n;
  logic [7:0] c8, c8_n;
  logic       e7m8, cdac8, e8, e_rise8, rsto_n8;

  logic [12:0] act1;
  logic [20:0] act2;
  assign act1 = {c, c_n, e7m, cdac, e, e_rise, rsto_n};
  assign act2 = {c8, c8_n, e7m8, cdac8, e8, e_rise8, rsto_n8};

  int checks   = 0;
  int failures = 0;

  // model state
  int m_cnt, m_ecnt, m_low, m_rem;
  bit m_run, m_ks1, m_ks2, m_erise;

  amiga_clock_gen u_dut (
    .i_clk(clk), .i_rst(rst), .i_sync(sync), .i_krst_n(krst_n),
    .o_c(c), .o_c_n(c_n), .o_e7m(e7m), .o_cdac(cdac), .o_e(e),
    .o_e_rise(e_rise), .o_rsto_n(rsto_n)
  );

  amiga_clock_gen #(.PHASES(8), .STEP(1)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_sync(sync), .i_krst_n(krst_n),
    .o_c(c8), .o_c_n(c8_n), .o_e7m(e7m8), .o_cdac(cdac8), .o_e(e8),
    .o_e_rise(e_rise8), .o_rsto_n(rsto_n8)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_c(int cnt, int phases, int step);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < phases; k++) r[k] = ((((cnt - k * step) % PER) + PER) % PER) < PER / 2;
    return r;
  endfunction

  function automatic logic exp_e7m(int cnt);
    return (cnt % (PER / 2)) < PER / 4;
  endfunction

  function automatic logic [12:0] exp_vec1();
    logic [7:0] cc;
    logic       ee;
    cc = exp_c(m_cnt, 4, 2);
    ee = exp_e7m(m_cnt);
    return {cc[3:0], ~cc[3:0], ee, ~ee, (m_ecnt >= ELOW), m_erise, (m_rem == 0)};
  endfunction

  function automatic logic [20:0] exp_vec2();
    logic [7:0] cc;
    logic       ee;
    cc = exp_c(m_cnt, 8, 1);
    ee = exp_e7m(m_cnt);
    return {cc, ~cc, ee, ~ee, (m_ecnt >= ELOW), m_erise, (m_rem == 0)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ecnt = 0; m_low = 0; m_rem = RSTLEN;
    m_run = 0; m_ks1 = 1; m_ks2 = 1; m_erise = 0;
  endtask

  // One master clock edge of the reference behaviour.
  task automatic model_step();
    int nc;
    bit tk, ks_seen, trig;
    ks_seen = m_ks2;
    m_ks2 = m_ks1;
    m_ks1 = krst_n;
    nc = sync ? 0 : (m_cnt + 1) % PER;
    tk = (nc == 0) || (m_run && nc == PER / 2);
    if (nc == 0) m_run = 1;
    m_cnt = nc;
    m_erise = 0;
    if (tk) begin
      m_ecnt = (m_ecnt + 1) % EDIV;
      m_erise = (m_ecnt == ELOW);
    end
    trig = 0;
    if (ks_seen) m_low = 0;
    else if (tk) begin
      m_low++;
      trig = (m_low == KHOLD);
    end
    if (trig) m_rem = RSTLEN;
    else if (tk && m_rem > 0) m_rem--;
  endtask

  // Advance one clock; return at the following falling edge for sampling.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst = 1; sync = 0; krst_n = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    n = 5 + $urandom_range(0, 20);
    for (int i = 0; i < n; i++) begin
      cyc();
      checks++;
      if (act1 !== exp_vec1()) begin
        failures++;
        $display("FAIL reset_run cyc=%0d actual=%h required=%h", i, act1, exp_vec1());
      end
    end
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if (act1 !== 13'b1001_0110_1_0_0_0_0) begin
      failures++;
      $display("FAIL reset_async actual=%b required=%b", act1, 13'b1001_0110_1_0_0_0_0);
    end
    checks++;
    if (act2 !== {8'b1110_0001, 8'b0001_1110, 5'b1_0_0_0_0}) begin
      failures++;
      $display("FAIL reset_async8 actual=%b required=%b", act2, {8'b1110_0001, 8'b0001_1110, 5'b1_0_0_0_0});
    end
    @(negedge clk);
    checks++;
    if (act1 !== exp_vec1()) begin
      failures++;
      $display("FAIL reset_held actual=%h required=%h", act1, exp_vec1());
    end
    rst = 0;
  endtask

  task automatic test_phase();
    logic [3:0] h_c[24];
    logic [7:0] h_c8[24];
    logic       h_e7m[24];
    int bad, ones;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) cyc();
      h_c[i] = c; h_c8[i] = c8; h_e7m[i] = e7m;
      checks++;
      if (act1 !== exp_vec1()) begin
        failures++;
        $display("FAIL phase cyc=%0d actual=%h required=%h", i, act1, exp_vec1());
      end
      checks++;
      if (act2 !== exp_vec2()) begin
        failures++;
        $display("FAIL phase8 cyc=%0d actual=%h required=%h", i, act2, exp_vec2());
      end
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(h_c[i][0]);
    checks++;
    if (ones != 4 || h_c[0][0] !== 1'b1 || h_c[4][0] !== 1'b0) begin
      failures++;
      $display("FAIL c0_duty actual=%0d high required=4 (starting high)", ones);
    end
    bad = 0;
    for (int i = 6; i < 24; i++)
      for (int k = 1; k < 4; k++) if (h_c[i][k] !== h_c[i - 2 * k][0]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL phase_lag actual=%0d errors required=0", bad);
    end
    bad = 0;
    for (int i = 7; i < 24; i++)
      for (int k = 1; k < 8; k++) if (h_c8[i][k] !== h_c8[i - k][0]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL phase_lag8 actual=%0d errors required=0", bad);
    end
    bad = 0;
    for (int i = 4; i < 24; i++) if (h_e7m[i] !== h_e7m[i - 4] || h_e7m[i] === h_e7m[i - 2]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL e7m_period actual=%0d errors required=0", bad);
    end
  endtask

  task automatic test_eclk();
    logic h_e[80], h_r[80];
    int highs, rises, bad;
    for (int i = 0; i < 80; i++) begin
      cyc();
      h_e[i] = e; h_r[i] = e_rise;
      checks++;
      if (act1 !== exp_vec1() || act2 !== exp_vec2()) begin
        failures++;
        $display("FAIL eclk cyc=%0d actual=%h/%h required=%h/%h", i, act1, act2, exp_vec1(), exp_vec2());
      end
    end
    highs = 0; rises = 0; bad = 0;
    for (int i = 40; i < 80; i++) begin
      highs += int'(h_e[i]);
      if (h_r[i]) begin
        rises++;
        if (h_e[i] !== 1'b1 || h_e[i - 1] !== 1'b0) bad++;
      end
    end
    checks++;
    if (highs != 16) begin
      failures++;
      $display("FAIL e_duty actual=%0d high required=16", highs);
    end
    checks++;
    if (rises != 1 || bad != 0) begin
      failures++;
      $display("FAIL e_rise actual=%0d pulses/%0d misplaced required=1/0", rises, bad);
    end
  endtask

  task automatic test_reset_stretch();
    int n;
    @(negedge clk);
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      checks++;
      if (act1 !== exp_vec1()) begin
        failures++;
        $display("FAIL stretch cyc=%0d actual=%h required=%h", i, act1, exp_vec1());
      end
      if (rsto_n === 1'b1) begin
        n = i;
        break;
      end
    end
    // first tick at the wrap 8 CLK after release, then 15 more ticks 4 CLK apart
    checks++;
    if (n != 68) begin
      failures++;
      $display("FAIL stretch_len actual=%0d required=68", n);
    end
  endtask

  task automatic test_genlock();
    int guard;
    for (int pos = 5; pos <= 7; pos += 2) begin
      guard = 0;
      while (m_cnt != pos && guard < 16) begin
        cyc();
        guard++;
      end
      checks++;
      if (m_cnt != pos) begin
        failures++;
        $display("FAIL sync_wait actual=%0d required=%0d", m_cnt, pos);
      end
      sync = 1;
      cyc();
      sync = 0;
      checks++;
      if (c !== 4'b1001 || e7m !== 1'b1 || c8 !== 8'b1110_0001) begin
        failures++;
        $display("FAIL sync_load at=%0d actual=%b/%b/%b required=1001/1/11100001", pos, c, e7m, c8);
      end
      for (int i = 0; i < 40; i++) begin
        cyc();
        checks++;
        if (act1 !== exp_vec1() || act2 !== exp_vec2()) begin
          failures++;
          $display("FAIL sync_run at=%0d cyc=%0d actual=%h/%h required=%h/%h", pos, i, act1, act2, exp_vec1(), exp_vec2());
        end
      end
    end
  endtask

  task automatic test_keyboard();
    int holds[3] = '{7, 8, 40};
    int pulses, lows;
    logic prev;
    for (int t = 0; t < 3; t++) begin
      pulses = 0; lows = 0; prev = rsto_n;
      krst_n = 0;
      for (int i = 0; i < 4 * holds[t] + 100; i++) begin
        if (i == 4 * holds[t]) krst_n = 1;
        cyc();
        checks++;
        if (act1 !== exp_vec1() || act2 !== exp_vec2()) begin
          failures++;
          $display("FAIL kbd hold=%0d cyc=%0d actual=%h/%h required=%h/%h", holds[t], i, act1, act2, exp_vec1(), exp_vec2());
        end
        if (prev === 1'b1 && rsto_n === 1'b0) pulses++;
        if (rsto_n === 1'b0) lows++;
        prev = rsto_n;
      end
      checks++;
      if (pulses != (holds[t] >= KHOLD ? 1 : 0) || lows != (holds[t] >= KHOLD ? 64 : 0)) begin
        failures++;
        $display("FAIL kbd_pulse hold=%0d actual=%0d pulses %0d low required=%0d/%0d", holds[t], pulses, lows,
                 (holds[t] >= KHOLD ? 1 : 0), (holds[t] >= KHOLD ? 64 : 0));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      sync = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) krst_n = ~krst_n;
      cyc();
      checks++;
      if (act1 !== exp_vec1() || act2 !== exp_vec2()) begin
        failures++;
        $display("FAIL random cyc=%0d actual=%h/%h required=%h/%h", i, act1, act2, exp_vec1(), exp_vec2());
      end
    end
    sync = 0;
    krst_n = 1;
  endtask

  initial begin
    test_reset();
    test_phase();
    test_eclk();
    test_reset_stretch();
    test_genlock();
    test_keyboard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
